// File: rtl/sd_rr_pick.sv
// rtl/sd_rr_pick.sv - combinational rotate-priority picker: first requester after 'last', wrapping
module sd_rr_pick #(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]         req,
    input  logic [$clog2(NUM_IN)-1:0] last,
    output logic                      found,
    output logic [$clog2(NUM_IN)-1:0] idx
);
    localparam int IW = $clog2(NUM_IN);

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NUM_IN; k >= 1; k--) begin
            j = (int'(last) + k) % NUM_IN;
            if (req[j]) begin
                found = 1'b1;
                idx   = j[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/sd_burst_arbiter.sv
// rtl/sd_burst_arbiter.sv - round-robin srdy/drdy arbiter with bounded burst tenure
module sd_burst_arbiter #(
    parameter int width     = 32,
    parameter int NUM_IN    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         c_srdy,
    output logic [NUM_IN-1:0]         c_drdy,
    input  logic [NUM_IN*width-1:0]   c_data,
    output logic                      p_srdy,
    input  logic                      p_drdy,
    output logic [width-1:0]          p_data,
    output logic [$clog2(NUM_IN)-1:0] p_grant
);
    localparam int GW = $clog2(NUM_IN);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_ptr;
    logic [BW-1:0]   bcnt;

    logic            xfer;
    logic            end_limit;
    logic            end_idle;
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   pick_last;

    always_comb begin
        c_drdy = '0;
        p_srdy = 1'b0;
        if (state == GRANT) begin
            p_srdy        = c_srdy[grant];
            c_drdy[grant] = p_drdy;
        end
        p_data  = c_data[grant*width +: width];
        p_grant = grant;
    end

    assign xfer      = (state == GRANT) && p_srdy && p_drdy;
    assign end_limit = xfer && (bcnt == BW'(MAX_BURST - 1));
    assign end_idle  = (state == GRANT) && !c_srdy[grant];

    // Scanning from grant+1 visits the owner last, so masking it on a burst-limit end
    // and falling back to a re-grant collapses into one unmasked pick.
    assign pick_last = (state == GRANT) ? grant : last_ptr;

    sd_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
        .req   (c_srdy),
        .last  (pick_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            last_ptr <= GW'(NUM_IN - 1);
            bcnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state <= GRANT;
                        grant <= pick_idx;
                        bcnt  <= '0;
                    end
                end
                GRANT: begin
                    if (end_limit || end_idle) begin
                        last_ptr <= grant;
                        bcnt     <= '0;
                        if (pick_found) begin
                            grant <= pick_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_burst_arbiter.sv
// tb/tb_sd_burst_arbiter.sv - directed vector table, reset corner case and randomized source traffic
module tb_sd_burst_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int WORDS = 1000;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   c_srdy = '0;
    logic [N-1:0]   c_drdy;
    logic [N*W-1:0] c_data = '0;
    logic           p_srdy;
    logic           p_drdy = 1'b0;
    logic [W-1:0]   p_data;
    logic [1:0]     p_grant;

    int tests = 0;
    int failed = 0;

    sd_burst_arbiter #(.width(W), .NUM_IN(N), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .reset   (reset),
        .c_srdy  (c_srdy),
        .c_drdy  (c_drdy),
        .c_data  (c_data),
        .p_srdy  (p_srdy),
        .p_drdy  (p_drdy),
        .p_data  (p_data),
        .p_grant (p_grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] srdy;
        logic       drdy;
        logic       exp_ps;
        logic [3:0] exp_cd;
        logic [1:0] exp_g;
        logic       chk_g;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] srdy, input logic drdy, input logic exp_ps,
                       input logic [3:0] exp_cd, input logic [1:0] exp_g, input logic chk_g);
        vec_t v;
        v.rst = rst; v.srdy = srdy; v.drdy = drdy; v.exp_ps = exp_ps;
        v.exp_cd = exp_cd; v.exp_g = exp_g; v.chk_g = chk_g;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i, input logic [29:0] s);
        return {i[1:0], s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        c_srdy = '0;
        reset  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    logic [29:0] seq [N];
    int          rx_cnt [N];
    int          wait_cnt [N];

    initial begin
        logic [7:0] pat;
        logic       d;
        int         cyc;
        logic [1:0] g;
        logic       xv;

        for (int i = 0; i < N; i++) c_data[i*W +: W] = word(i, 30'h1234 + 30'(i));

        // 1: all requesters busy, full burst rotation
        add(1, 4'b1111, 1, 0, 4'b0000, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            int gi;
            gi = ((k - 1) / 4) % 4;
            add(0, 4'b1111, 1, 1, 4'(1 << gi), 2'(gi), 1);
        end
        // 2: lone requester 2, 10 words then drops
        add(1, 4'b0100, 1, 0, 4'b0000, 0, 0);
        for (int k = 1; k <= 10; k++) add(0, 4'b0100, 1, 1, 4'b0100, 2, 1);
        add(0, 4'b0000, 1, 0, 4'b0100, 2, 1);
        add(0, 4'b0000, 1, 0, 4'b0000, 0, 0);
        // 3: requesters 1 and 3, p_drdy cycling 8'h03
        pat = 8'h03;
        add(1, 4'b1010, pat[0], 0, 4'b0000, 0, 0);
        for (int c = 1; c <= 16; c++) begin
            d = pat[c % 8];
            add(0, 4'b1010, d, 1, d ? 4'b0010 : 4'b0000, 1, 1);
        end
        add(0, 4'b1010, pat[1], 1, 4'b1000, 3, 1);
        // 4: requester 0 goes idle after 2 words while 1 waits
        add(1, 4'b0011, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b0011, 1, 1, 4'b0001, 0, 1);
        add(0, 4'b0011, 1, 1, 4'b0001, 0, 1);
        add(0, 4'b0010, 1, 0, 4'b0001, 0, 1);
        for (int k = 0; k < 4; k++) add(0, 4'b0011, 1, 1, 4'b0010, 1, 1);
        add(0, 4'b0011, 1, 1, 4'b0001, 0, 1);

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset p_srdy", 32'(p_srdy), 0);
        check("reset c_drdy", 32'(c_drdy), 0);
        check("reset p_grant", 32'(p_grant), 0);
        check("reset p_data", p_data, word(0, 30'h1234));
        @(negedge clk);
        reset = 1'b1;
        tick();

        foreach (vecs[n]) begin
            if (vecs[n].rst) do_reset();
            c_srdy = vecs[n].srdy;
            p_drdy = vecs[n].drdy;
            @(negedge clk);
            check($sformatf("vec%0d p_srdy", n), 32'(p_srdy), 32'(vecs[n].exp_ps));
            check($sformatf("vec%0d c_drdy", n), 32'(c_drdy), 32'(vecs[n].exp_cd));
            if (vecs[n].chk_g) begin
                check($sformatf("vec%0d p_grant", n), 32'(p_grant), 32'(vecs[n].exp_g));
                check($sformatf("vec%0d p_data", n), p_data, word(int'(vecs[n].exp_g), 30'h1234 + 30'(vecs[n].exp_g)));
            end
            tick();
        end

        // 5: reset mid-burst of requester 1 (bcnt=2, last_ptr=0) returns priority to 0
        do_reset();
        c_srdy = 4'b0011;
        p_drdy = 1'b1;
        repeat (7) tick();
        check("pre-reset p_grant", 32'(p_grant), 1);
        check("pre-reset c_drdy", 32'(c_drdy), 32'b0010);
        reset = 1'b0;
        #1;
        check("async reset c_drdy", 32'(c_drdy), 0);
        check("async reset p_srdy", 32'(p_srdy), 0);
        check("async reset p_grant", 32'(p_grant), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post-reset p_grant", 32'(p_grant), 0);
        check("post-reset c_drdy", 32'(c_drdy), 32'b0001);
        check("post-reset p_srdy", 32'(p_srdy), 1);

        // 6: random sources, in-order delivery and bounded waiting
        do_reset();
        for (int i = 0; i < N; i++) begin
            seq[i] = '0; rx_cnt[i] = 0; wait_cnt[i] = 0;
            c_data[i*W +: W] = word(i, 30'h0);
        end
        cyc = 0;
        xv = 1'b0;
        g = '0;
        while ((rx_cnt[0] < WORDS || rx_cnt[1] < WORDS || rx_cnt[2] < WORDS || rx_cnt[3] < WORDS) && cyc < 60000) begin
            if (xv) begin
                seq[g] = seq[g] + 30'd1;
                c_data[int'(g)*W +: W] = word(int'(g), seq[g]);
                c_srdy[g] = (rx_cnt[g] < WORDS) && ($urandom_range(0, 1) == 1);
            end
            p_drdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (!c_srdy[i] && rx_cnt[i] < WORDS && $urandom_range(0, 1) == 1) c_srdy[i] = 1'b1;
            @(negedge clk);
            check("rand c_drdy onehot", 32'($countones(c_drdy) <= 1), 1);
            check("rand xfer agree", 32'(|(c_srdy & c_drdy)), 32'(p_srdy && p_drdy));
            xv = p_srdy && p_drdy;
            if (xv) begin
                g = p_grant;
                check("rand p_data", p_data, word(int'(g), seq[g]));
                rx_cnt[g]++;
                wait_cnt[g] = 0;
                for (int i = 0; i < N; i++) begin
                    if (i != int'(g) && c_srdy[i]) begin
                        wait_cnt[i]++;
                        check($sformatf("rand wait bound src%0d", i), 32'(wait_cnt[i] <= 3 * MB), 1);
                    end
                end
            end
            tick();
            cyc++;
        end
        check("rand cycle budget", 32'(cyc < 60000), 1);
        for (int i = 0; i < N; i++) check($sformatf("rand rx_cnt src%0d", i), 32'(rx_cnt[i]), 32'(WORDS));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
